// File: rtl/ce_tick_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ce_tick_scheduler : N-channel periodic/one-shot tick generator on a base CE
// Revision: 1.0
// ---------------------------------------------------------------------------
module ce_tick_scheduler #(
  parameter int par_num_chan  = 4,
  parameter int par_cnt_width = 16,
  localparam int CHAN_W = (par_num_chan > 1) ? $clog2(par_num_chan) : 1
) (
  input  logic                     i_clk_mhz,
  input  logic                     i_rst_mhz_n,
  input  logic                     i_ce_mhz,
  input  logic                     i_cfg_valid,
  output logic                     o_cfg_ready,
  input  logic [CHAN_W-1:0]        i_cfg_chan,
  input  logic                     i_cfg_start,
  input  logic                     i_cfg_oneshot,
  input  logic [par_cnt_width-1:0] i_cfg_period,
  output logic                     o_cfg_err,
  output logic [par_num_chan-1:0]  o_tick,
  output logic [par_num_chan-1:0]  o_running,
  output logic [par_num_chan-1:0]  o_expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } chan_state_t;

  logic                     accept;
  logic                     cmd_bad;
  logic                     cmd_pending;
  logic [CHAN_W-1:0]        cmd_chan;
  logic                     cmd_start;
  logic                     cmd_oneshot;
  logic [par_cnt_width-1:0] cmd_period;

  assign accept  = i_cfg_valid && o_cfg_ready;
  assign cmd_bad = (int'(i_cfg_chan) >= par_num_chan) ||
                   (i_cfg_start && (i_cfg_period == '0));

  // Command is captured on accept and applied one cycle later; ready stays
  // low during that apply cycle so commands can never overlap.
  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
    if (!i_rst_mhz_n) begin
      o_cfg_ready <= 1'b0;
      o_cfg_err   <= 1'b0;
      cmd_pending <= 1'b0;
      cmd_chan    <= '0;
      cmd_start   <= 1'b0;
      cmd_oneshot <= 1'b0;
      cmd_period  <= '0;
    end else begin
      o_cfg_ready <= !accept;
      o_cfg_err   <= accept && cmd_bad;
      cmd_pending <= accept;
      if (accept) begin
        cmd_chan    <= i_cfg_chan;
        cmd_start   <= i_cfg_start;
        cmd_oneshot <= i_cfg_oneshot;
        cmd_period  <= i_cfg_period;
      end
    end
  end

  for (genvar g = 0; g < par_num_chan; g++) begin : g_chan
    chan_state_t              state;
    logic [par_cnt_width-1:0] count;
    logic [par_cnt_width-1:0] period;
    logic                     oneshot;
    logic                     tick_q;
    logic                     expired_q;
    logic                     hit;
    logic                     terminal;

    // An out-of-range channel index never matches, so it leaves all channels alone.
    assign hit      = cmd_pending && (cmd_chan == CHAN_W'(g));
    assign terminal = (count == period - par_cnt_width'(1));

    always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
      if (!i_rst_mhz_n) begin
        state     <= IDLE;
        count     <= '0;
        period    <= '0;
        oneshot   <= 1'b0;
        tick_q    <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (hit) begin
          // A command always wins over a coincident terminal count.
          count     <= '0;
          expired_q <= 1'b0;
          if (cmd_start && (cmd_period != '0)) begin
            state   <= RUN;
            period  <= cmd_period;
            oneshot <= cmd_oneshot;
          end else begin
            state <= IDLE;
          end
        end else if ((state == RUN) && i_ce_mhz) begin
          if (terminal) begin
            tick_q <= 1'b1;
            count  <= '0;
            if (oneshot) begin
              state     <= EXPIRED;
              expired_q <= 1'b1;
            end
          end else begin
            count <= count + par_cnt_width'(1);
          end
        end
      end
    end

    assign o_tick[g]    = tick_q;
    assign o_running[g] = (state == RUN);
    assign o_expired[g] = expired_q;
  end

endmodule
`default_nettype wire
